lsu_byte_seq: RTL and testbench

- Load/store initiator that sits between the pipeline MEM stage and the byte-wide data memory.
- Turns one RISC-V load/store request (byte, half or word) into a sequence of single-byte memory accesses, in little-endian order.
- For loads, assembles the bytes and sign- or zero-extends the result.
- Holds the pipeline with a busy signal until the access completes.
- Memory side assumes a combinational read and a write committed on the rising clock edge.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_ext.sv | 14 +
 rtl/lsu_byte_seq.sv | 121 ++++++++++++
 tb/tb_lsu_byte_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned XLEN = 32;

  // Zero marks an illegal funct3.
  function automatic logic [2:0] lsu_byte_count(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lsu_extend(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] w);
    case (f3)
      F3_B:    return {{24{w[7]}}, w[7:0]};
      F3_BU:   return {24'h000000, w[7:0]};
      F3_H:    return {{16{w[15]}}, w[15:0]};
      F3_HU:   return {16'h0000, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extender for assembled load data.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = lsu_extend(funct3, word);
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Turns one B/H/W load or store into a little-endian sequence of byte
// accesses on a byte-wide memory, holding the pipeline with busy.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [BYTE_WIDTH-1:0]    mem_wd,
  input  logic [BYTE_WIDTH-1:0]    mem_rd
);

  state_t                   state;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    asm_q;
  logic [DATA_WIDTH-1:0]    asm_next;
  logic [DATA_WIDTH-1:0]    ext_word;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [1:0]               idx;
  logic [1:0]               last_idx;
  logic                     err_q;
  logic [2:0]               req_count;

  assign req_count = lsu_byte_count(req_funct3);

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign err   = err_q;
  assign rdata = rdata_q;

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (state == XFER) begin
      mem_a = addr_q + ADDRESS_WIDTH'(idx);
      if (we_q) begin
        mem_we = 1'b1;
        mem_wd = wdata_q[BYTE_WIDTH*int'(idx) +: BYTE_WIDTH];
      end
    end
  end

  // Includes the byte arriving this cycle so the final extend can be
  // registered on the same edge that enters DONE.
  always_comb begin
    asm_next = asm_q;
    asm_next[BYTE_WIDTH*int'(idx) +: BYTE_WIDTH] = mem_rd;
  end

  lsu_load_ext u_ext (
    .funct3 (f3_q),
    .word   (asm_next),
    .rdata  (ext_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      rdata_q  <= '0;
      idx      <= '0;
      last_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            asm_q    <= '0;
            idx      <= '0;
            last_idx <= 2'(req_count - 3'd1);
            if (req_count == 3'd0) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (!we_q) asm_q <= asm_next;
          if (idx == last_idx) begin
            state <= DONE;
            if (!we_q) rdata_q <= ext_word;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Scoreboard bench for lsu_byte_seq with a 64-byte aliased memory model.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a;
  logic [7:0]  mem_wd, mem_rd;

  lsu_byte_seq #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .BYTE_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [64];
  logic       mem_clr;
  assign mem_rd = mem[mem_a[5:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_a[5:0]] <= mem_wd;
    end
  end

  typedef struct { logic e; logic [31:0] rd; int acc; int lat; } rsp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    rsp_t r;
    wr_t  w;
    if (!rst) begin
      if (mem_we) begin
        check("we_only_when_busy", {31'd0, busy}, 32'd1);
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%02h", mem_a, mem_wd);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_a, w.a);
          check("wr_data", {24'd0, mem_wd}, {24'd0, w.d});
        end
      end
      if (done) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: err %0b rdata 0x%08h", err, rdata);
        end else begin
          r = rsp_q.pop_front();
          check("done_err", {31'd0, err}, {31'd0, r.e});
          check("done_rdata", rdata, r.rd);
          check("done_latency", 32'(cyc - r.acc), 32'(r.lat));
          check("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit push_done, input int nwr, input bit hold);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL issue_timeout: busy stuck at 1, expected 0");
    end else begin
      if (push_done) rsp_q.push_back('{e: exp_err, rd: exp_rd, acc: cyc, lat: lat});
      for (int i = 0; i < nwr; i++)
        wr_q.push_back('{a: addr + 32'(i), d: 8'(wdata >> (8 * i))});
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, busy},   32'd0);
    check({tag, "_done"},   {31'd0, done},   32'd0);
    check({tag, "_err"},    {31'd0, err},    32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_a"},  mem_a,           32'd0);
    check({tag, "_mem_wd"}, {24'd0, mem_wd}, 32'd0);
    check({tag, "_rdata"},  rdata,           32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    mem_clr = 1'b0;
    rst = 1'b0;

    // we, f3, addr, wdata, exp_rdata, exp_err, latency, push_done, writes, hold
    issue(1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0,         0, 5, 1, 4, 0); // SW
    issue(0, 3'b010, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 0, 5, 1, 0, 0); // LW
    issue(1, 3'b000, 32'h0001_0008, 32'h1234_5680, 32'hDEAD_BEEF, 0, 2, 1, 1, 0); // SB 0x80
    issue(0, 3'b000, 32'h0001_0008, 32'h0,         32'hFFFF_FF80, 0, 2, 1, 0, 0); // LB
    issue(0, 3'b100, 32'h0001_0008, 32'h0,         32'h0000_0080, 0, 2, 1, 0, 0); // LBU
    issue(1, 3'b001, 32'h0001_0003, 32'h0000_F234, 32'h0000_0080, 0, 3, 1, 2, 0); // SH misaligned
    issue(0, 3'b001, 32'h0001_0003, 32'h0,         32'hFFFF_F234, 0, 3, 1, 0, 0); // LH
    issue(0, 3'b101, 32'h0001_0003, 32'h0,         32'h0000_F234, 0, 3, 1, 0, 0); // LHU
    issue(0, 3'b011, 32'h0001_0000, 32'h0,         32'h0000_F234, 1, 1, 1, 0, 0); // illegal load
    issue(1, 3'b111, 32'h0001_0000, 32'h5555_5555, 32'h0000_F234, 1, 1, 1, 0, 0); // illegal store
    issue(0, 3'b010, 32'h0001_0000, 32'h0,         32'h34AD_BEEF, 0, 5, 1, 0, 0); // LW clears err
    issue(1, 3'b001, 32'hFFFF_FFFE, 32'h0000_2211, 32'h34AD_BEEF, 0, 3, 1, 2, 0); // SH top
    issue(0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'hBEEF_2211, 0, 5, 1, 0, 0); // LW wraps
    issue(1, 3'b001, 32'hFFFF_FFFF, 32'h0000_A55A, 32'hBEEF_2211, 0, 3, 1, 2, 0); // SH wraps
    issue(0, 3'b101, 32'hFFFF_FFFF, 32'h0,         32'h0000_A55A, 0, 3, 1, 0, 0); // LHU wraps
    issue(1, 3'b010, 32'h0001_0020, 32'h4433_2211, 32'h0000_A55A, 0, 5, 1, 4, 0); // SW preload

    // Store interrupted by reset after two bytes
    issue(1, 3'b010, 32'h0001_0020, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 2, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("partial_b0", {24'd0, mem[32]}, 32'h0D);
    check("partial_b1", {24'd0, mem[33]}, 32'hF0);
    check("partial_b2", {24'd0, mem[34]}, 32'h33);
    check("partial_b3", {24'd0, mem[35]}, 32'h44);
    issue(0, 3'b010, 32'h0001_0020, 32'h0, 32'h4433_F00D, 0, 5, 1, 0, 0); // LW after reset

    // Back-to-back with req_valid held high
    issue(0, 3'b000, 32'h0001_0008, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 0, 1);
    issue(0, 3'b101, 32'h0001_0003, 32'h0, 32'h0000_F234, 0, 3, 1, 0, 1);
    issue(0, 3'b010, 32'h0001_0000, 32'h0, 32'h34AD_BEA5, 0, 5, 1, 0, 0);

    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pending_responses", 32'(rsp_q.size()), 32'd0);
    check("pending_writes", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
